// File: rtl/sparc_pkg.sv
// Shared SPARC window constants and the spill/fill engine state encoding.
package sparc_pkg;

    localparam int WIN_BITS       = 2;
    localparam int NWINDOWS       = 4;
    localparam int REG_SPILL_BASE = 16;
    localparam int WORDS_PER_WIN  = 16;

    localparam logic OP_SPILL = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SP_RD,
        ST_SP_CAP,
        ST_SP_MEM,
        ST_FL_MEM,
        ST_FL_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/window_spill_fill_if.sv
// Command, register-file and memory signals of the window spill/fill engine.
interface window_spill_fill_if
    import sparc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WIN_BITS = sparc_pkg::WIN_BITS
);

    logic                start;
    logic                op;
    logic [WIN_BITS-1:0] window;
    logic [ADDR_W-1:0]   base_addr;
    logic                busy;
    logic                done;
    logic                err;

    logic                rf_enable;
    logic                rf_rw;
    logic [WIN_BITS-1:0] rf_window;
    logic [4:0]          rf_r_num;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   rf_rdata;

    // Memory handshake: mem_req acts as valid and is held with stable
    // address/data until mem_ack (ready); the transfer completes in the
    // cycle where both are high, and mem_req is low the cycle after.
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    state_t              dbg_state;

    modport master (
        input  start, op, window, base_addr, rf_rdata, mem_rdata, mem_ack,
        output busy, done, err, rf_enable, rf_rw, rf_window, rf_r_num,
               rf_wdata, mem_req, mem_we, mem_addr, mem_wdata, dbg_state
    );

    modport slave (
        output start, op, window, base_addr, rf_rdata, mem_rdata, mem_ack,
        input  busy, done, err, rf_enable, rf_rw, rf_window, rf_r_num,
               rf_wdata, mem_req, mem_we, mem_addr, mem_wdata, dbg_state
    );

endinterface

// File: rtl/window_spill_fill.sv
// Moves the 16 private registers (r16..r31) of one window between the
// windowed register file and consecutive memory words.
module window_spill_fill
    import sparc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WIN_BITS = sparc_pkg::WIN_BITS
) (
    input  logic                Clk,
    input  logic                Clr,
    window_spill_fill_if.master bus
);

    state_t              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [WIN_BITS-1:0] window_q, window_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic                err_q, err_d;
    logic                last_word;

    assign last_word = (k_q == 4'(WORDS_PER_WIN - 1));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        window_d = window_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        fdata_d  = fdata_q;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    window_d = bus.window;
                    base_d   = bus.base_addr;
                    k_d      = '0;
                    if (bus.base_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (bus.op == OP_FILL) begin
                        state_d = ST_FL_MEM;
                    end else begin
                        state_d = ST_SP_RD;
                    end
                end
            end
            ST_SP_RD:  state_d = ST_SP_CAP;
            ST_SP_CAP: begin
                // RF read data arrives one cycle after the read strobe.
                wdata_d = bus.rf_rdata;
                state_d = ST_SP_MEM;
            end
            ST_SP_MEM: begin
                if (bus.mem_ack) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = ST_SP_RD;
                    end
                end
            end
            ST_FL_MEM: begin
                if (bus.mem_ack) begin
                    fdata_d = bus.mem_rdata;
                    state_d = ST_FL_WR;
                end
            end
            ST_FL_WR: begin
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = ST_FL_MEM;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            window_q <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            fdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            window_q <= window_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            fdata_q  <= fdata_d;
            err_q    <= err_d;
        end
    end

    // Address and register number are gated so that idle outputs read as zero.
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
    assign bus.rf_enable = (state_q == ST_SP_RD) || (state_q == ST_FL_WR);
    assign bus.rf_rw     = (state_q == ST_FL_WR);
    assign bus.rf_window = bus.busy ? window_q : '0;
    assign bus.rf_r_num  = bus.rf_enable ? (5'(REG_SPILL_BASE) + 5'(k_q)) : '0;
    assign bus.rf_wdata  = fdata_q;
    assign bus.mem_req   = (state_q == ST_SP_MEM) || (state_q == ST_FL_MEM);
    assign bus.mem_we    = (state_q == ST_SP_MEM);
    assign bus.mem_addr  = bus.mem_req ? (base_q + (ADDR_W'(k_q) << 2)) : '0;
    assign bus.mem_wdata = wdata_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_window_spill_fill.sv
// Directed and randomized spill/fill runs against behavioural RF and memory models.
module tb_window_spill_fill;
  import sparc_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  window_spill_fill_if bus ();
  window_spill_fill dut (.Clk(clk), .Clr(clr), .bus(bus));

  int total = 0;
  int bad   = 0;

  // behavioural models (only the model processes write these)
  logic [31:0] rf_arr  [4][32];
  logic [31:0] mem_arr [bit [31:0]];
  logic [63:0] wr_log  [$];
  int          rf_wr_cnt = 0, bad_reg_cnt = 0, done_cnt = 0, err_cnt = 0, win_bad_cnt = 0;
  bit          rd_pend = 1'b0;
  logic [1:0]  rd_w;
  logic [4:0]  rd_r;
  int          wait_cnt = 0;

  // written only by the stimulus process
  logic [31:0] rf_init  [4][32];
  logic [31:0] mem_init [bit [31:0]];
  bit          rf_load = 1'b0, mem_load = 1'b0;
  int          ack_delay = 0;
  logic [1:0]  exp_win = '0;

  // register file: one-cycle read latency, junk on rf_rdata otherwise
  always @(negedge clk) begin
    if (rf_load) rf_arr = rf_init;
    bus.rf_rdata = rd_pend ? rf_arr[rd_w][rd_r] : $urandom;
    rd_pend = 1'b0;
    if (bus.rf_enable) begin
      if (bus.rf_r_num < 5'd16) bad_reg_cnt++;
      if (bus.rf_rw) begin
        rf_arr[bus.rf_window][bus.rf_r_num] = bus.rf_wdata;
        rf_wr_cnt++;
      end else begin
        rd_pend = 1'b1;
        rd_w    = bus.rf_window;
        rd_r    = bus.rf_r_num;
      end
    end
    if (bus.busy && bus.rf_window !== exp_win) win_bad_cnt++;
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
  end

  // memory: ack after ack_delay wait cycles
  always @(negedge clk) begin
    if (mem_load) mem_arr = mem_init;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    if (bus.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        wait_cnt    = 0;
        if (bus.mem_we) begin
          mem_arr[bus.mem_addr] = bus.mem_wdata;
          wr_log.push_back({bus.mem_addr, bus.mem_wdata});
        end else begin
          bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_models();
    rf_load  = 1'b1;
    mem_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rf_load  = 1'b0;
    mem_load = 1'b0;
  endtask

  task automatic randomize_models();
    for (int w = 0; w < 4; w++)
      for (int r = 0; r < 32; r++)
        rf_init[w][r] = $urandom;
    mem_init.delete();
  endtask

  function automatic logic [63:0] idle_outputs();
    return {bus.busy, bus.done, bus.err, bus.rf_enable, bus.rf_rw, bus.rf_window,
            bus.rf_r_num, bus.mem_req, bus.mem_we, bus.mem_addr};
  endfunction

  // driver: issues a command at a negedge and counts cycles up to done
  task automatic run_cmd(input bit op_i, input logic [1:0] w, input logic [31:0] base,
                         input int delay, input int inject_at, output int cycles);
    exp_win       = w;
    ack_delay     = delay;
    bus.start     = 1'b1;
    bus.op        = op_i;
    bus.window    = w;
    bus.base_addr = base;
    cycles        = 1;
    while (cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (cycles == inject_at) begin
        bus.start     = 1'b1;
        bus.op        = ~op_i;
        bus.window    = w + 2'd1;
        bus.base_addr = base ^ 32'h0000_0102;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // scoreboard for a spill: expected {addr,data} queue vs. the memory write log
  task automatic verify_spill(input string tag, input logic [1:0] w, input logic [31:0] base,
                              input int log_start);
    logic [63:0] exp_q [$];
    logic [63:0] got;
    for (int k = 0; k < 16; k++) exp_q.push_back({base + 32'(4 * k), rf_init[w][16 + k]});
    check({tag, "_nwords"}, 64'(wr_log.size() - log_start), 64'd16);
    for (int k = 0; k < 16; k++) begin
      got = (log_start + k < wr_log.size()) ? wr_log[log_start + k] : '1;
      check($sformatf("%s_w%0d", tag, k), got, exp_q.pop_front());
    end
  endtask

  task automatic verify_fill(input string tag, input logic [1:0] fw, input logic [31:0] base);
    int          diffs = 0;
    logic [31:0] e;
    for (int w = 0; w < 4; w++)
      for (int r = 0; r < 32; r++) begin
        if (w == int'(fw) && r >= 16) e = mem_init[base + 32'(4 * (r - 16))];
        else e = rf_init[w][r];
        if (rf_arr[w][r] !== e) diffs++;
      end
    check({tag, "_rf_diffs"}, 64'(diffs), 64'd0);
  endtask

  initial begin
    int cyc, log0, wr0, done0, err0, d;
    bit op_r;
    logic [1:0] w_r;
    logic [31:0] b_r;
    logic sticky;

    bus.start = 1'b0; bus.op = 1'b0; bus.window = '0; bus.base_addr = '0;
    randomize_models();
    load_models();
    repeat (2) @(negedge clk);
    check("reset_outputs", idle_outputs(), 64'd0);
    check("reset_data", {bus.mem_wdata, bus.rf_wdata}, 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    clr = 1'b0;
    @(negedge clk);

    // spill window 2, base 0x1000, immediate ack
    for (int k = 0; k < 16; k++) rf_init[2][16 + k] = 32'hA0 + 32'(k);
    load_models();
    log0 = wr_log.size(); wr0 = rf_wr_cnt; done0 = done_cnt; err0 = err_cnt;
    run_cmd(OP_SPILL, 2'd2, 32'h1000, 0, 0, cyc);
    check("spill_cycles", 64'(cyc), 64'd50);
    verify_spill("spill", 2'd2, 32'h1000, log0);
    check("spill_rf_writes", 64'(rf_wr_cnt - wr0), 64'd0);
    check("spill_done_pulses", 64'(done_cnt - done0), 64'd1);
    check("spill_busy_after", 64'(bus.busy), 64'd0);

    // fill window 1, base 0x2000, ack delay 3
    randomize_models();
    for (int k = 0; k < 16; k++) mem_init[32'h2000 + 32'(4 * k)] = 32'hB0 + 32'(k);
    load_models();
    log0 = wr_log.size(); wr0 = rf_wr_cnt;
    run_cmd(OP_FILL, 2'd1, 32'h2000, 3, 0, cyc);
    check("fill_cycles", 64'(cyc), 64'd82);
    verify_fill("fill", 2'd1, 32'h2000);
    check("fill_rf_writes", 64'(rf_wr_cnt - wr0), 64'd16);
    check("fill_mem_writes", 64'(wr_log.size() - log0), 64'd0);

    // misaligned base is rejected
    err0 = err_cnt;
    bus.start = 1'b1; bus.op = OP_SPILL; bus.window = 2'd0; bus.base_addr = 32'h1002;
    @(negedge clk);
    bus.start = 1'b0;
    check("misalign_err", 64'(bus.err), 64'd1);
    check("misalign_busy", 64'(bus.busy), 64'd0);
    sticky = 1'b0;
    repeat (5) begin
      sticky = sticky | bus.busy | bus.mem_req | bus.rf_enable;
      @(negedge clk);
    end
    check("misalign_quiet", 64'(sticky), 64'd0);
    check("misalign_err_pulses", 64'(err_cnt - err0), 64'd1);

    // second start during spill word 5 is ignored
    randomize_models();
    load_models();
    log0 = wr_log.size(); done0 = done_cnt; err0 = err_cnt;
    run_cmd(OP_SPILL, 2'd3, 32'h3000, 0, 18, cyc);
    check("inject_cycles", 64'(cyc), 64'd50);
    verify_spill("inject", 2'd3, 32'h3000, log0);
    check("inject_err", 64'(err_cnt - err0), 64'd0);
    check("inject_done_pulses", 64'(done_cnt - done0), 64'd1);

    // Clr while word 7 waits on memory
    randomize_models();
    load_models();
    log0 = wr_log.size(); done0 = done_cnt;
    exp_win = 2'd0; ack_delay = 5;
    bus.start = 1'b1; bus.op = OP_SPILL; bus.window = 2'd0; bus.base_addr = 32'h4000;
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (!(bus.mem_req && bus.mem_addr == 32'h401C) && cyc < 500);
    check("clr_reached_word7", 64'(bus.mem_addr), 64'h401C);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_outputs", idle_outputs(), 64'd0);
    check("clr_data", {bus.mem_wdata, bus.rf_wdata}, 64'd0);
    clr = 1'b0;
    sticky = 1'b0;
    repeat (8) begin
      sticky = sticky | bus.done | bus.mem_req | bus.rf_enable;
      @(negedge clk);
    end
    check("clr_quiet", 64'(sticky), 64'd0);
    check("clr_no_done", 64'(done_cnt - done0), 64'd0);
    check("clr_partial_words", 64'(wr_log.size() - log0), 64'd7);
    randomize_models();
    for (int k = 0; k < 16; k++) mem_init[32'h5000 + 32'(4 * k)] = $urandom;
    load_models();
    run_cmd(OP_FILL, 2'd0, 32'h5000, 1, 0, cyc);
    check("post_clr_fill_cycles", 64'(cyc), 64'd50);
    verify_fill("post_clr_fill", 2'd0, 32'h5000);

    // address wrap at the top of memory
    randomize_models();
    load_models();
    log0 = wr_log.size(); err0 = err_cnt;
    run_cmd(OP_SPILL, 2'd1, 32'hFFFF_FFF8, 0, 0, cyc);
    verify_spill("wrap", 2'd1, 32'hFFFF_FFF8, log0);
    check("wrap_err", 64'(err_cnt - err0), 64'd0);

    // randomized commands
    for (int i = 0; i < 6; i++) begin
      op_r = 1'($urandom_range(0, 1));
      w_r  = 2'($urandom_range(0, 3));
      b_r  = $urandom & 32'hFFFF_FFFC;
      d    = $urandom_range(0, 3);
      randomize_models();
      if (op_r == OP_FILL)
        for (int k = 0; k < 16; k++) mem_init[b_r + 32'(4 * k)] = $urandom;
      load_models();
      log0 = wr_log.size();
      run_cmd(op_r, w_r, b_r, d, 0, cyc);
      if (op_r == OP_FILL) begin
        check($sformatf("rnd%0d_fill_cycles", i), 64'(cyc), 64'(2 + 16 * (2 + d)));
        verify_fill($sformatf("rnd%0d_fill", i), w_r, b_r);
      end else begin
        check($sformatf("rnd%0d_spill_cycles", i), 64'(cyc), 64'(2 + 16 * (3 + d)));
        verify_spill($sformatf("rnd%0d_spill", i), w_r, b_r, log0);
      end
    end

    check("window_always_latched", 64'(win_bad_cnt), 64'd0);
    check("no_global_or_out_access", 64'(bad_reg_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
